pocq_sched: RTL and testbench
=============================

Name: pocq_sched

Overview:
- Per-entry transaction scheduler for the HN-F point-of-coherence queue.
- Tracks the lifecycle of every queue slot: allocate, issue downstream, completion, CompAck release.
- Round-robin arbitrates pending slots onto a single downstream issue port and caps the number of outstanding downstream requests.
- Produces the release pulse that tells the queue to free a slot, plus occupancy status for upstream flow control.

Parameters:
- DEPTH, 16, number of queue slots; power of two, at least 2.
- MAX_OUT, 8, maximum slots in ISSUED at once; 1..DEPTH.
- IDW, $clog2(DEPTH), slot index width (derived, not overridden).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- alloc_v  in  1  slot alloc_idx was filled this cycle.
- alloc_idx  in  IDW  slot being allocated.
- issue_v  out  1  a PEND slot is offered downstream.
- issue_idx  out  IDW  slot offered.
- issue_rdy  in  1  downstream accepts; handshake = issue_v & issue_rdy.
- comp_v  in  1  completion/data returned for slot comp_idx.
- comp_idx  in  IDW  slot completed.
- ack_v  in  1  CompAck received for slot ack_idx.
- ack_idx  in  IDW  slot acknowledged.
- release_v  out  1  one-cycle pulse: queue must clear release_idx.
- release_idx  out  IDW  slot to clear.
- free_cnt  out  IDW+1  number of FREE slots.
- full  out  1  free_cnt == 0.
- empty  out  1  free_cnt == DEPTH.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset low, async):
  - All slots FREE; RR pointer = DEPTH-1; issue lock clear; outstanding count = 0.
  - Outputs: issue_v=0, issue_idx=0, release_v=0, release_idx=0, free_cnt=DEPTH, full=0, empty=1, proto_err=0.
  - Reset asserted mid-transaction discards all state; no release pulses are generated for discarded slots.
- Per-slot states are FREE, PEND, ISSUED and WAIT_ACK. All transitions take effect on the next clock edge.
- FREE->PEND on alloc_v.
  - If alloc_v targets a non-FREE slot: ignore it and set proto_err.
- PEND->ISSUED on the issue handshake for that slot.
- ISSUED->WAIT_ACK on comp_v.
  - If comp_v targets a slot not in ISSUED: ignore it and set proto_err.
- WAIT_ACK->FREE on ack_v.
  - If ack_v targets a slot not in WAIT_ACK: ignore it and set proto_err.
- Release pulse: a legal ack at cycle N drives release_v=1 and release_idx=ack_idx during cycle N+1 (registered).
  - release_v=0 in all other cycles.
  - release_idx holds its last value when release_v=0.
- Arbitration:
  - issue_v and issue_idx are registered.
  - Candidates are PEND slots, searched from RR pointer+1 upward, wrapping modulo DEPTH; the first one found wins.
  - issue_v is suppressed while outstanding == MAX_OUT.
- Offer stability:
  - Once issue_v=1, issue_v and issue_idx hold until the handshake.
  - New allocations cannot pre-empt the held offer.
- On handshake:
  - The RR pointer becomes issue_idx.
  - issue_v may re-assert the next cycle with the next winner, so back-to-back issue of one slot per cycle is possible.
- Outstanding counter:
  - +1 on handshake, -1 on legal comp; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUT and never underflows.
- Latency:
  - alloc at N -> earliest issue_v at N+1.
  - comp at N -> slot in WAIT_ACK at N+1.
  - ack at N -> release at N+1.
- Simultaneous events:
  - alloc, handshake, comp and ack on distinct slots in the same cycle all take effect.
  - ack and alloc to the same slot in the same cycle: the ack applies and the alloc is illegal (slot is not FREE at that edge), so proto_err is set.
- Occupancy:
  - free_cnt, full and empty are registered and reflect slot states after the edge.
  - A same-cycle alloc and release leaves free_cnt unchanged.
  - An alloc while full is illegal: ignored, proto_err set.
- proto_err clears only on reset.

Test Plan:
- Alloc slot 3 at cycle 0, issue_rdy=1 -> issue_v=1 and issue_idx=3 at cycle 1; comp 3 at cycle 3, ack 3 at cycle 5 -> release_v=1, release_idx=3 at cycle 6; free_cnt returns to 16.
- Alloc slots 0, 5 and 9 together, issue_rdy=1 -> issue order 0, 5, 9 on consecutive cycles; re-alloc 0 after release -> served only after the pointer wraps past 9.
- issue_rdy=0 with slot 7 offered, then alloc slot 2 -> issue_idx stays 7 until issue_rdy=1; then 2 is issued next cycle.
- MAX_OUT=8: alloc 10 slots, issue_rdy=1 -> exactly 8 handshakes and issue_v low; one comp -> one further issue.
- Alloc all 16 -> full=1, free_cnt=0; a 17th alloc -> ignored, proto_err=1; an ack to a PEND slot also sets proto_err with no release pulse.
- Drop reset with 4 slots ISSUED -> all outputs at reset values asynchronously; after reset is released, empty=1 and no release pulses occur.

Source files
------------

// File: rtl/pocq_sched.sv
// -----------------------------------------------------------------------------
// pocq_sched
// Per-slot lifecycle scheduler for the HN-F point-of-coherence queue.
//
// Each slot moves FREE -> PEND -> ISSUED -> WAIT_ACK -> FREE. PEND slots are
// round-robin arbitrated onto one downstream issue port. The number of ISSUED
// slots is capped at MAX_OUT. A legal CompAck produces a one-cycle release
// pulse so the queue can clear the slot. Any illegal request is ignored and
// sets a sticky error flag.
//
// Ports:
//   clock                      rising-edge clock
//   reset                      asynchronous, active-low reset
//   alloc_v / alloc_idx        slot allocated this cycle
//   issue_v / issue_idx        registered downstream offer (held until taken)
//   issue_rdy                  downstream accept; handshake = issue_v & issue_rdy
//   comp_v / comp_idx          completion returned for an ISSUED slot
//   ack_v / ack_idx            CompAck for a WAIT_ACK slot
//   release_v / release_idx    registered one-cycle slot-release pulse
//   free_cnt / full / empty    registered occupancy status
//   proto_err                  sticky protocol-violation flag
// -----------------------------------------------------------------------------
module pocq_sched #(
  parameter int DEPTH   = 16,
  parameter int MAX_OUT = 8,
  localparam int IDW    = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           alloc_v,
  input  logic [IDW-1:0] alloc_idx,
  output logic           issue_v,
  output logic [IDW-1:0] issue_idx,
  input  logic           issue_rdy,
  input  logic           comp_v,
  input  logic [IDW-1:0] comp_idx,
  input  logic           ack_v,
  input  logic [IDW-1:0] ack_idx,
  output logic           release_v,
  output logic [IDW-1:0] release_idx,
  output logic [IDW:0]   free_cnt,
  output logic           full,
  output logic           empty,
  output logic           proto_err
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_ISSUED = 2'd2;
  localparam logic [1:0] S_WACK   = 2'd3;

  localparam logic [IDW:0]   MAX_OUT_C = (IDW+1)'(MAX_OUT);
  localparam logic [IDW:0]   DEPTH_C   = (IDW+1)'(DEPTH);
  localparam logic [IDW-1:0] RR_INIT   = IDW'(DEPTH - 1);

  logic [DEPTH-1:0][1:0] st_q, st_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [IDW:0]          out_q, out_d;
  logic [IDW:0]          free_d;

  logic           hs, alloc_ok, comp_ok, ack_ok, err_d;
  logic           found;
  logic [IDW-1:0] win, cand;
  logic           issue_v_d;
  logic [IDW-1:0] issue_idx_d;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    st_d     = st_q;
    hs       = issue_v & issue_rdy;
    alloc_ok = alloc_v && (st_q[alloc_idx] == S_FREE);
    comp_ok  = comp_v  && (st_q[comp_idx]  == S_ISSUED);
    ack_ok   = ack_v   && (st_q[ack_idx]   == S_WACK);
    err_d    = (alloc_v && !alloc_ok) || (comp_v && !comp_ok) || (ack_v && !ack_ok);

    // Each legal event requires a different current state, so the four
    // updates can never target the same slot and their order is irrelevant.
    // An alloc to a slot being acked this cycle fails the FREE test above.
    if (hs)       st_d[issue_idx] = S_ISSUED;
    if (comp_ok)  st_d[comp_idx]  = S_WACK;
    if (ack_ok)   st_d[ack_idx]   = S_FREE;
    if (alloc_ok) st_d[alloc_idx] = S_PEND;

    unique case ({hs, comp_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    unique case ({alloc_ok, ack_ok})
      2'b10:   free_d = free_cnt - 1'b1;
      2'b01:   free_d = free_cnt + 1'b1;
      default: free_d = free_cnt;
    endcase

    rr_d = hs ? issue_idx : rr_q;

    // Search the post-edge state from rr_d+1 upward; DEPTH is a power of two,
    // so IDW-bit addition wraps modulo DEPTH for free.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      cand = rr_d + IDW'(k);
      if (!found && st_d[cand] == S_PEND) begin
        found = 1'b1;
        win   = cand;
      end
    end

    // A pending offer is held until taken; it was only made while below
    // MAX_OUT and the count only rises on a handshake, so it stays legal.
    if (issue_v && !hs) begin
      issue_v_d   = 1'b1;
      issue_idx_d = issue_idx;
    end else if (found && out_d != MAX_OUT_C) begin
      issue_v_d   = 1'b1;
      issue_idx_d = win;
    end else begin
      issue_v_d   = 1'b0;
      issue_idx_d = issue_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  // NOTE: the slot-state array is a small flop bank, not a RAM, so it is reset
  // with everything else; reset must return every slot to FREE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q        <= '0;
      rr_q        <= RR_INIT;
      out_q       <= '0;
      issue_v     <= 1'b0;
      issue_idx   <= '0;
      release_v   <= 1'b0;
      release_idx <= '0;
      free_cnt    <= DEPTH_C;
      full        <= 1'b0;
      empty       <= 1'b1;
      proto_err   <= 1'b0;
    end else begin
      st_q      <= st_d;
      rr_q      <= rr_d;
      out_q     <= out_d;
      issue_v   <= issue_v_d;
      issue_idx <= issue_idx_d;
      release_v <= ack_ok;
      if (ack_ok) release_idx <= ack_idx;
      free_cnt  <= free_d;
      full      <= (free_d == '0);
      empty     <= (free_d == DEPTH_C);
      if (err_d) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pocq_sched.sv
// -----------------------------------------------------------------------------
// tb_pocq_sched
// Directed self-checking bench for pocq_sched (DEPTH=16, MAX_OUT=8).
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so a value driven in cycle N is seen by the edge ending N.
// -----------------------------------------------------------------------------
module tb_pocq_sched;

  localparam int DEPTH = 16;
  localparam int IDW   = 4;

  logic           clock;
  logic           reset;
  logic           alloc_v;
  logic [IDW-1:0] alloc_idx;
  logic           issue_v;
  logic [IDW-1:0] issue_idx;
  logic           issue_rdy;
  logic           comp_v;
  logic [IDW-1:0] comp_idx;
  logic           ack_v;
  logic [IDW-1:0] ack_idx;
  logic           release_v;
  logic [IDW-1:0] release_idx;
  logic [IDW:0]   free_cnt;
  logic           full;
  logic           empty;
  logic           proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  pocq_sched #(.DEPTH(DEPTH), .MAX_OUT(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_v     (alloc_v),
    .alloc_idx   (alloc_idx),
    .issue_v     (issue_v),
    .issue_idx   (issue_idx),
    .issue_rdy   (issue_rdy),
    .comp_v      (comp_v),
    .comp_idx    (comp_idx),
    .ack_v       (ack_v),
    .ack_idx     (ack_idx),
    .release_v   (release_v),
    .release_idx (release_idx),
    .free_cnt    (free_cnt),
    .full        (full),
    .empty       (empty),
    .proto_err   (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock: the edge consumes the current inputs, then pulses are cleared.
  task automatic step();
    @(posedge clock);
    #1;
    alloc_v = 1'b0;
    comp_v  = 1'b0;
    ack_v   = 1'b0;
  endtask

  task automatic do_reset();
    alloc_v = 0; alloc_idx = 0; comp_v = 0; comp_idx = 0;
    ack_v = 0; ack_idx = 0; issue_rdy = 0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    do_reset();
    n_cmp++; if (issue_v !== 1'b0) begin n_bad++; $display("FAIL rst_issue_v got %0d want 0", issue_v); end
    n_cmp++; if (issue_idx !== 4'd0) begin n_bad++; $display("FAIL rst_issue_idx got %0d want 0", issue_idx); end
    n_cmp++; if (release_v !== 1'b0 || release_idx !== 4'd0) begin n_bad++; $display("FAIL rst_release got v=%0d idx=%0d want 0/0", release_v, release_idx); end
    n_cmp++; if (free_cnt !== 5'd16 || full !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL rst_occ got free=%0d full=%0d empty=%0d want 16/0/1", free_cnt, full, empty); end
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_proto_err got %0d want 0", proto_err); end
  endtask

  task automatic test_single();
    do_reset();
    issue_rdy = 1; alloc_v = 1; alloc_idx = 3; step();          // cycle 1
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd3) begin n_bad++; $display("FAIL single_issue got v=%0d idx=%0d want 1/3", issue_v, issue_idx); end
    n_cmp++; if (free_cnt !== 5'd15 || empty !== 1'b0) begin n_bad++; $display("FAIL single_free got %0d/%0d want 15/0", free_cnt, empty); end
    step();                                                     // cycle 2
    n_cmp++; if (issue_v !== 1'b0) begin n_bad++; $display("FAIL single_issue_drop got %0d want 0", issue_v); end
    step();                                                     // cycle 3
    comp_v = 1; comp_idx = 3; step();                           // cycle 4
    step();                                                     // cycle 5
    ack_v = 1; ack_idx = 3; step();                             // cycle 6
    n_cmp++; if (release_v !== 1'b1 || release_idx !== 4'd3) begin n_bad++; $display("FAIL single_release got v=%0d idx=%0d want 1/3", release_v, release_idx); end
    n_cmp++; if (free_cnt !== 5'd16 || empty !== 1'b1) begin n_bad++; $display("FAIL single_free_back got %0d/%0d want 16/1", free_cnt, empty); end
    step();
    n_cmp++; if (release_v !== 1'b0 || release_idx !== 4'd3) begin n_bad++; $display("FAIL single_release_hold got v=%0d idx=%0d want 0/3", release_v, release_idx); end
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL single_proto_err got %0d want 0", proto_err); end
  endtask

  task automatic test_round_robin();
    do_reset();
    issue_rdy = 0;
    alloc_v = 1; alloc_idx = 0; step();
    alloc_v = 1; alloc_idx = 5; step();
    alloc_v = 1; alloc_idx = 9; step();
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd0) begin n_bad++; $display("FAIL rr_first got v=%0d idx=%0d want 1/0", issue_v, issue_idx); end
    issue_rdy = 1; step();                                      // slot 0 taken
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd5) begin n_bad++; $display("FAIL rr_second got v=%0d idx=%0d want 1/5", issue_v, issue_idx); end
    step();                                                     // slot 5 taken
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd9) begin n_bad++; $display("FAIL rr_third got v=%0d idx=%0d want 1/9", issue_v, issue_idx); end
    issue_rdy = 0;
    comp_v = 1; comp_idx = 0; step();
    ack_v = 1; ack_idx = 0; step();
    n_cmp++; if (release_v !== 1'b1 || release_idx !== 4'd0) begin n_bad++; $display("FAIL rr_release got v=%0d idx=%0d want 1/0", release_v, release_idx); end
    alloc_v = 1; alloc_idx = 0; step();
    step();
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd9) begin n_bad++; $display("FAIL rr_hold9 got v=%0d idx=%0d want 1/9", issue_v, issue_idx); end
    issue_rdy = 1; step();                                      // slot 9 taken, wrap to 0
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd0) begin n_bad++; $display("FAIL rr_wrap got v=%0d idx=%0d want 1/0", issue_v, issue_idx); end
    step();
    n_cmp++; if (issue_v !== 1'b0) begin n_bad++; $display("FAIL rr_idle got %0d want 0", issue_v); end
  endtask

  task automatic test_hold();
    do_reset();
    issue_rdy = 0;
    alloc_v = 1; alloc_idx = 7; step();
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd7) begin n_bad++; $display("FAIL hold_offer got v=%0d idx=%0d want 1/7", issue_v, issue_idx); end
    alloc_v = 1; alloc_idx = 2; step();
    step();
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd7) begin n_bad++; $display("FAIL hold_stable got v=%0d idx=%0d want 1/7", issue_v, issue_idx); end
    issue_rdy = 1; step();
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd2) begin n_bad++; $display("FAIL hold_next got v=%0d idx=%0d want 1/2", issue_v, issue_idx); end
    step();
    n_cmp++; if (issue_v !== 1'b0) begin n_bad++; $display("FAIL hold_idle got %0d want 0", issue_v); end
  endtask

  task automatic test_max_out();
    int hs_cnt;
    int last_idx;
    do_reset();
    hs_cnt = 0; last_idx = -1;
    issue_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      if (i < 10) begin alloc_v = 1; alloc_idx = IDW'(i); end
      if (issue_v && issue_rdy) begin hs_cnt++; last_idx = int'(issue_idx); end
      step();
    end
    n_cmp++; if (hs_cnt !== 8) begin n_bad++; $display("FAIL max_hs got %0d want 8", hs_cnt); end
    n_cmp++; if (issue_v !== 1'b0) begin n_bad++; $display("FAIL max_stall got %0d want 0", issue_v); end
    comp_v = 1; comp_idx = 0; step();
    for (int i = 0; i < 6; i++) begin
      if (issue_v && issue_rdy) begin hs_cnt++; last_idx = int'(issue_idx); end
      step();
    end
    n_cmp++; if (hs_cnt !== 9 || last_idx !== 8) begin n_bad++; $display("FAIL max_resume got hs=%0d idx=%0d want 9/8", hs_cnt, last_idx); end
    n_cmp++; if (issue_v !== 1'b0) begin n_bad++; $display("FAIL max_restall got %0d want 0", issue_v); end
  endtask

  task automatic test_full_and_errors();
    do_reset();
    issue_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      alloc_v = 1; alloc_idx = IDW'(i); step();
    end
    n_cmp++; if (full !== 1'b1 || free_cnt !== 5'd0 || proto_err !== 1'b0) begin n_bad++; $display("FAIL full_set got full=%0d free=%0d err=%0d want 1/0/0", full, free_cnt, proto_err); end
    alloc_v = 1; alloc_idx = 4; step();
    n_cmp++; if (proto_err !== 1'b1 || free_cnt !== 5'd0) begin n_bad++; $display("FAIL full_alloc got err=%0d free=%0d want 1/0", proto_err, free_cnt); end
    // Separate run: CompAck to a PEND slot.
    do_reset();
    alloc_v = 1; alloc_idx = 4; step();
    ack_v = 1; ack_idx = 4; step();
    n_cmp++; if (proto_err !== 1'b1 || release_v !== 1'b0) begin n_bad++; $display("FAIL ack_pend got err=%0d rel=%0d want 1/0", proto_err, release_v); end
    n_cmp++; if (free_cnt !== 5'd15) begin n_bad++; $display("FAIL ack_pend_free got %0d want 15", free_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_rdy = 1;
    alloc_v = 1; alloc_idx = 1; step();                         // offer 1
    step();                                                     // 1 issued
    comp_v = 1; comp_idx = 1; step();                           // 1 in WAIT_ACK
    ack_v = 1; ack_idx = 1; alloc_v = 1; alloc_idx = 2; step();
    n_cmp++; if (free_cnt !== 5'd15 || release_v !== 1'b1 || release_idx !== 4'd1) begin n_bad++; $display("FAIL b2b_alloc_release got free=%0d rel=%0d idx=%0d want 15/1/1", free_cnt, release_v, release_idx); end
    n_cmp++; if (issue_v !== 1'b1 || issue_idx !== 4'd2 || proto_err !== 1'b0) begin n_bad++; $display("FAIL b2b_issue got v=%0d idx=%0d err=%0d want 1/2/0", issue_v, issue_idx, proto_err); end
    step();                                                     // 2 issued
    comp_v = 1; comp_idx = 2; step();
    ack_v = 1; ack_idx = 2; alloc_v = 1; alloc_idx = 2; step(); // same-slot ack+alloc
    n_cmp++; if (release_v !== 1'b1 || proto_err !== 1'b1 || free_cnt !== 5'd16) begin n_bad++; $display("FAIL b2b_same_slot got rel=%0d err=%0d free=%0d want 1/1/16", release_v, proto_err, free_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      alloc_v = 1; alloc_idx = IDW'(i); step();
    end
    step();
    comp_v = 1; comp_idx = 0; step();
    ack_v = 1; ack_idx = 0;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (issue_v !== 1'b0 || issue_idx !== 4'd0 || release_v !== 1'b0 || release_idx !== 4'd0) begin n_bad++; $display("FAIL mid_rst_outs got iv=%0d ii=%0d rv=%0d ri=%0d want 0", issue_v, issue_idx, release_v, release_idx); end
    n_cmp++; if (free_cnt !== 5'd16 || empty !== 1'b1 || full !== 1'b0 || proto_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_occ got free=%0d empty=%0d full=%0d err=%0d want 16/1/0/0", free_cnt, empty, full, proto_err); end
    ack_v = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      n_cmp++; if (release_v !== 1'b0 || empty !== 1'b1 || issue_v !== 1'b0) begin n_bad++; $display("FAIL mid_rst_after%0d got rel=%0d empty=%0d iv=%0d want 0/1/0", i, release_v, empty, issue_v); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_max_out();
    test_full_and_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
